// File: rtl/conv_seq_ctrl_if.sv
// Handshake and memory-control bundle between the convolution sequencer and its datapath.
// With CONV_STALL_CNT_EN defined the bundle also carries the 16-bit output stall counter.
interface conv_seq_ctrl_if #(
    parameter int unsigned F_AW = 2,
    parameter int unsigned X_AW = 3
) ();
    logic            s_valid;
    logic            s_ready;
    logic            f_wr_en;
    logic [F_AW-1:0] f_wr_addr;
    logic            x_wr_en;
    logic [X_AW-1:0] x_wr_addr;
    logic [X_AW-1:0] rd_xaddr;
    logic [F_AW-1:0] rd_faddr;
    logic            mac_en;
    logic            mac_clear;
    logic            m_valid_y;
    logic            m_ready_y;
    logic            conv_done;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    // Sequencer side
    modport master (
`ifdef CONV_STALL_CNT_EN
        output stall_cnt,
`endif
        input  s_valid, m_ready_y,
        output s_ready, f_wr_en, f_wr_addr, x_wr_en, x_wr_addr,
        output rd_xaddr, rd_faddr, mac_en, mac_clear, m_valid_y, conv_done
    );

    // Producer / datapath / consumer side
    modport slave (
`ifdef CONV_STALL_CNT_EN
        input  stall_cnt,
`endif
        output s_valid, m_ready_y,
        input  s_ready, f_wr_en, f_wr_addr, x_wr_en, x_wr_addr,
        input  rd_xaddr, rd_faddr, mac_en, mac_clear, m_valid_y, conv_done
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution engine: loads F then X words from one stream, walks
// every output window through the MAC, and hands each y to the consumer.
// Optional feature macro: CONV_STALL_CNT_EN adds a saturating output-stall cycle counter.
module conv_seq_ctrl #(
    parameter int unsigned F_MEM_SIZE       = 4,
    parameter int unsigned X_MEM_SIZE       = 8,
    parameter int unsigned X_MEM_ADDR_WIDTH = 3,
    parameter int unsigned F_MEM_ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    conv_seq_ctrl_if.master   bus
);
    localparam int unsigned NUM_OUT = X_MEM_SIZE - F_MEM_SIZE + 1;
    localparam int unsigned XW      = X_MEM_ADDR_WIDTH;
    localparam int unsigned FW      = F_MEM_ADDR_WIDTH;

    localparam logic [XW-1:0] F_LAST   = XW'(F_MEM_SIZE - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(X_MEM_SIZE - 1);
    localparam logic [FW-1:0] TAP_LAST = FW'(F_MEM_SIZE - 1);
    localparam logic [XW-1:0] WIN_LAST = XW'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        StLoadF,
        StLoadX,
        StCompute,
        StDrain,
        StOutput
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] cnt_q, cnt_d;     // load word index, shared by F and X phases
    logic [XW-1:0] win_q, win_d;     // current output window
    logic [FW-1:0] tap_q, tap_d;     // current filter tap
    logic          mac_en_q, mac_clear_q;

    logic          s_valid, m_ready_y;
    logic          s_ready, f_wr_en, x_wr_en, conv_done;

    assign s_valid   = bus.s_valid;
    assign m_ready_y = bus.m_ready_y;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoadF;
            cnt_q   <= '0;
            win_q   <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            tap_q   <= tap_d;
        end
    end

    // MAC controls lag address issue by one cycle to line up with sync-read memory data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
        end else begin
            mac_en_q    <= (state_q == StCompute);
            mac_clear_q <= (state_q == StCompute) && (tap_q == '0);
        end
    end

    // Next-state, counter updates and combinational strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        tap_d     = tap_q;
        s_ready   = 1'b0;
        f_wr_en   = 1'b0;
        x_wr_en   = 1'b0;
        conv_done = 1'b0;
        unique case (state_q)
            StLoadF: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    f_wr_en = 1'b1;
                    if (cnt_q == F_LAST) begin
                        cnt_d   = '0;
                        state_d = StLoadX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLoadX: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    x_wr_en = 1'b1;
                    if (cnt_q == X_LAST) begin
                        cnt_d   = '0;
                        win_d   = '0;
                        tap_d   = '0;
                        state_d = StCompute;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                // tap holds at its last value so addresses stay frozen through DRAIN/OUTPUT
                if (tap_q == TAP_LAST) begin
                    state_d = StDrain;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StDrain: begin
                state_d = StOutput;
            end
            StOutput: begin
                if (m_ready_y) begin
                    tap_d = '0;
                    if (win_q == WIN_LAST) begin
                        conv_done = 1'b1;
                        win_d     = '0;
                        state_d   = StLoadF;
                    end else begin
                        win_d   = win_q + 1'b1;
                        state_d = StCompute;
                    end
                end
            end
            default: begin
                state_d = StLoadF;
            end
        endcase
        // State sits in LOAD_F during reset; keep the load strobes quiet there too
        if (reset) begin
            s_ready   = 1'b0;
            f_wr_en   = 1'b0;
            x_wr_en   = 1'b0;
            conv_done = 1'b0;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.f_wr_en   = f_wr_en;
    assign bus.f_wr_addr = cnt_q[FW-1:0];
    assign bus.x_wr_en   = x_wr_en;
    assign bus.x_wr_addr = cnt_q;
    assign bus.rd_xaddr  = win_q + XW'(tap_q);
    assign bus.rd_faddr  = tap_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clear = mac_clear_q;
    assign bus.m_valid_y = (state_q == StOutput);
    assign bus.conv_done = conv_done;

`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Cycles a valid y waits on the consumer; restarts with the first F word of a job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (state_q == StLoadF && s_valid && cnt_q == '0) begin
            stall_cnt_q <= '0;
        end else if (state_q == StOutput && !m_ready_y && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: default F=4/X=8 instance plus an F=X=4 instance.
module tb_conv_seq_ctrl;
    logic clk;
    logic reset;
    logic reset1;
    int   vecs;
    int   errs;

    conv_seq_ctrl_if #(.F_AW(2), .X_AW(3)) bus0 ();
    conv_seq_ctrl_if #(.F_AW(2), .X_AW(2)) bus1 ();

    conv_seq_ctrl #(
        .F_MEM_SIZE(4), .X_MEM_SIZE(8), .X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    conv_seq_ctrl #(
        .F_MEM_SIZE(4), .X_MEM_SIZE(4), .X_MEM_ADDR_WIDTH(2), .F_MEM_ADDR_WIDTH(2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released at posedge+1: the following cycle is cycle 0
    task automatic do_reset();
        reset = 1'b1;
        bus0.s_valid = 1'b0;
        bus0.m_ready_y = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        do_reset();
        bus0.s_valid = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        // now in LOAD_X with x_wr_en high; assert reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        obs = {bus0.s_ready, bus0.f_wr_en, bus0.f_wr_addr, bus0.x_wr_en, bus0.x_wr_addr,
               bus0.rd_xaddr, bus0.rd_faddr, bus0.mac_en, bus0.mac_clear, bus0.m_valid_y,
               bus0.conv_done, 4'b0};
        vecs++;
        if (obs !== 22'd0) begin
            errs++;
            $display("FAIL reset_async_outputs got=%h want=0", obs);
        end
        tick();
        bus0.s_valid = 1'b0;
        reset = 1'b0;
        #1;
        vecs++;
        if (bus0.s_ready !== 1'b1 || bus0.f_wr_en !== 1'b0 || bus0.m_valid_y !== 1'b0) begin
            errs++;
            $display("FAIL reset_release got s_ready=%b f_wr_en=%b m_valid_y=%b want 1 0 0",
                     bus0.s_ready, bus0.f_wr_en, bus0.m_valid_y);
        end
    endtask

    // Continuous s_valid/m_ready_y job: write addresses, window timing, read addresses
    task automatic test_stream(input string tag);
        logic [11:0] obs, expv;
        logic        e_fen, e_xen, e_mac, e_clr, e_mv, e_done, e_rdy;
        logic [1:0]  e_fa;
        logic [2:0]  e_xa;
        int          k, ph;
        do_reset();
        for (int c = 0; c <= 41; c++) begin
            bus0.s_valid = 1'b1;
            bus0.m_ready_y = 1'b1;
            @(negedge clk);
            e_rdy = (c <= 11);
            e_fen = (c <= 3);
            e_fa  = e_fen ? 2'(c) : 2'd0;
            e_xen = (c >= 4 && c <= 11);
            e_xa  = e_xen ? 3'(c - 4) : 3'd0;
            k = (c >= 12) ? (c - 12) / 6 : 0;
            ph = (c >= 12) ? (c - 12) % 6 : -1;
            e_mac  = (ph >= 1 && ph <= 4);
            e_clr  = (ph == 1);
            e_mv   = (ph == 5);
            e_done = (c == 41);
            expv = {e_rdy, e_fen, e_fa, e_xen, e_xa, e_mac, e_clr, e_mv, e_done};
            obs = {bus0.s_ready, bus0.f_wr_en, bus0.f_wr_en ? bus0.f_wr_addr : 2'd0,
                   bus0.x_wr_en, bus0.x_wr_en ? bus0.x_wr_addr : 3'd0, bus0.mac_en,
                   bus0.mac_clear, bus0.m_valid_y, bus0.conv_done};
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL %s cycle %0d ctrl got=%b want=%b", tag, c, obs, expv);
            end
            if (ph >= 0 && ph <= 3) begin
                vecs++;
                if (bus0.rd_xaddr !== 3'(k + ph) || bus0.rd_faddr !== 2'(ph)) begin
                    errs++;
                    $display("FAIL %s cycle %0d rd_addr got x=%0d f=%0d want x=%0d f=%0d",
                             tag, c, bus0.rd_xaddr, bus0.rd_faddr, k + ph, ph);
                end
            end
            tick();
        end
        bus0.s_valid = 1'b0;
    endtask

    // Consumer stalls window 0 for 10 cycles
    task automatic test_backpressure();
        logic e_mv, e_done;
        do_reset();
        for (int c = 0; c <= 54; c++) begin
            bus0.s_valid = (c < 12) || (c == 53);
            bus0.m_ready_y = !(c >= 17 && c <= 26);
            @(negedge clk);
            e_mv = (c >= 17 && c <= 27) || c == 33 || c == 39 || c == 45 || c == 51;
            e_done = (c == 51);
            vecs++;
            if (bus0.m_valid_y !== e_mv || bus0.conv_done !== e_done) begin
                errs++;
                $display("FAIL stall cycle %0d got m_valid_y=%b conv_done=%b want %b %b",
                         c, bus0.m_valid_y, bus0.conv_done, e_mv, e_done);
            end
            if (c >= 17 && c <= 27) begin
                vecs++;
                if (bus0.mac_en !== 1'b0 || bus0.rd_xaddr !== 3'd3 || bus0.rd_faddr !== 2'd3)
                begin
                    errs++;
                    $display("FAIL stall_frozen cycle %0d got mac_en=%b x=%0d f=%0d want 0 3 3",
                             c, bus0.mac_en, bus0.rd_xaddr, bus0.rd_faddr);
                end
            end
`ifdef CONV_STALL_CNT_EN
            if (c == 27 || c == 52 || c == 54) begin
                vecs++;
                if (bus0.stall_cnt !== ((c == 54) ? 16'd0 : 16'd10)) begin
                    errs++;
                    $display("FAIL stall_cnt cycle %0d got=%0d want=%0d", c, bus0.stall_cnt,
                             (c == 54) ? 0 : 10);
                end
            end
`endif
            tick();
        end
        bus0.s_valid = 1'b0;
    endtask

    // Gapped load, then s_valid held high through compute
    task automatic test_gapped_load();
        logic [9:0] obs, expv;
        logic       e_fen, e_xen, e_rdy;
        logic [1:0] e_fa;
        logic [2:0] e_xa;
        int         idx;
        do_reset();
        bus0.m_ready_y = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            bus0.s_valid = (c < 24) ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            idx = c / 2;
            e_rdy = (c < 23);
            e_fen = (c < 24) && (c % 2 == 0) && (idx < 4);
            e_xen = (c < 24) && (c % 2 == 0) && (idx >= 4);
            e_fa = e_fen ? 2'(idx) : 2'd0;
            e_xa = e_xen ? 3'(idx - 4) : 3'd0;
            expv = {e_rdy, e_fen, e_fa, e_xen, e_xa, (c == 28)};
            obs = {bus0.s_ready, bus0.f_wr_en, bus0.f_wr_en ? bus0.f_wr_addr : 2'd0,
                   bus0.x_wr_en, bus0.x_wr_en ? bus0.x_wr_addr : 3'd0, bus0.m_valid_y};
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL gapped cycle %0d got=%b want=%b", c, obs, expv);
            end
            tick();
        end
        bus0.s_valid = 1'b0;
    endtask

    // Abort in window 3, then a clean job
    task automatic test_abort();
        do_reset();
        for (int c = 0; c <= 31; c++) begin
            bus0.s_valid = 1'b1;
            bus0.m_ready_y = 1'b1;
            if (c < 31) tick();
        end
        @(negedge clk);
        vecs++;
        if (bus0.mac_en !== 1'b1 || bus0.mac_clear !== 1'b1 || bus0.rd_xaddr !== 3'd4) begin
            errs++;
            $display("FAIL abort_pre got mac_en=%b mac_clear=%b x=%0d want 1 1 4",
                     bus0.mac_en, bus0.mac_clear, bus0.rd_xaddr);
        end
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if (bus0.mac_en !== 1'b0 || bus0.rd_xaddr !== 3'd0 || bus0.s_ready !== 1'b0) begin
            errs++;
            $display("FAIL abort_async got mac_en=%b x=%0d s_ready=%b want 0 0 0",
                     bus0.mac_en, bus0.rd_xaddr, bus0.s_ready);
        end
        tick();
        test_stream("after_abort");
    endtask

    // F=X=4: exactly one window
    task automatic test_single_window();
        logic [2:0] obs, expv;
        reset1 = 1'b1;
        bus1.s_valid = 1'b0;
        bus1.m_ready_y = 1'b1;
        tick();
        reset1 = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            bus1.s_valid = (c < 8);
            @(negedge clk);
            expv = {(c < 8) || (c >= 14), (c == 13), (c == 13)};
            obs = {bus1.s_ready, bus1.m_valid_y, bus1.conv_done};
            vecs++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL single_window cycle %0d got=%b want=%b", c, obs, expv);
            end
            tick();
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        reset = 1'b1;
        reset1 = 1'b1;
        bus0.s_valid = 1'b0;
        bus0.m_ready_y = 1'b0;
        bus1.s_valid = 1'b0;
        bus1.m_ready_y = 1'b0;
        tick();
        test_reset();
        test_stream("stream");
        test_backpressure();
        test_gapped_load();
        test_abort();
        test_single_window();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
